vreg_writeback_seq: RTL and testbench
=====================================

Name: vreg_writeback_seq

Overview:
- Writeback sequencer that drives the single byte-enabled write port of the vector register file.
- Accepts one writeback command (vd, LMUL, SEW, vl, mask mode), then one result beat per register of the group.
- Converts vl, SEW and the per-element mask into per-byte write enables and issues one registered write per beat.
- Sits between the execute/result stage and the vector register file write port.

Parameters:
- REG_LEN, 64, vector register width in bits
- NUM_REGS, 8, number of architectural vector registers
- ADDR_W, $clog2(NUM_REGS), register address width
- LANES, REG_LEN/8, byte lanes per register
- VL_W, $clog2(LANES*4)+1, vl field width (max vl = LANES*4 at SEW8, LMUL4)

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_vd  in  ADDR_W  destination base register
- cmd_lmul  in  2  log2 group size: 0=1, 1=2, 2=4 registers; 3 treated as 2
- cmd_sew  in  2  element width: 0=8b, 1=16b, 2=32b; 3 treated as 2
- cmd_vl  in  VL_W  active element count
- cmd_vm  in  1  1=unmasked, 0=apply beat_vmask
- beat_valid  in  1  result beat valid
- beat_ready  out  1  beat accepted when beat_valid & beat_ready
- beat_data  in  REG_LEN  result data for current register of group
- beat_vmask  in  LANES  per-local-element mask bits; bit i = element i of this beat
- wr_addr  out  ADDR_W  register file write address
- wr_en  out  LANES  register file byte write enables
- wr_data  out  REG_LEN  register file write data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle misaligned-command pulse

Behaviour:
- Reset (async, nreset low): state IDLE, beat counter k=0. Outputs: wr_addr=0, wr_en=0, wr_data=0, done=0, err=0, busy=0, beat_ready=0. cmd_ready=1 once reset is released.
- FSM states: IDLE, BEAT, FLUSH.
- IDLE:
  - cmd_ready=1. On accept, latch all cmd_* fields and set k=0.
  - If cmd_vd is not a multiple of 2^lmul: err=1 next cycle, no beats, stay IDLE.
  - Else if cmd_vl==0: done=1 next cycle, no beats, stay IDLE.
  - Else go to BEAT.
- BEAT:
  - beat_ready=1, busy=1. Each accepted beat registers a write on the next cycle (1-cycle latency).
  - wr_addr = (vd + k) mod NUM_REGS. wr_data = beat_data.
  - Byte b enable: e = k*(LANES>>sew) + (b>>sew); en = (e < vl_eff) & (vm | beat_vmask[b>>sew]).
  - vl_eff = min(vl, (LANES>>sew) << lmul).
  - wr_en forced to 0 when wr_addr==0 (register 0 is never written).
  - Beat with k == 2^lmul-1 is the last beat: go to FLUSH. Otherwise k increments.
- FLUSH (one cycle): the final write is presented, done=1, busy=0, return to IDLE. cmd_ready=0 in FLUSH.
- Outputs between beats: wr_en=0 on every cycle with no accepted beat; wr_addr and wr_data hold their last values.
- Backpressure: beat_valid gaps stall k indefinitely. Commands are never accepted while busy or in FLUSH.
- Tail registers: all 2^lmul beats are always consumed, even when vl covers fewer registers. Those beats get wr_en=0 but are still presented on the port.
- Reset mid-operation aborts the command immediately: no further writes, no done pulse.

Test Plan:
- SEW8 LMUL1 vd=3 vl=5 vm=1, beat_data=0x1122334455667788 -> next cycle wr_addr=3, wr_en=0x1F, wr_data=0x1122334455667788; done=1 one cycle after beat accept; cmd_ready=1 following cycle.
- SEW16 LMUL2 vd=4 vl=6 vm=1, two beats -> writes wr_addr=4 wr_en=0xFF, then wr_addr=5 wr_en=0x0F; done=1 one cycle after second beat accept.
- SEW32 LMUL1 vd=2 vl=2 vm=0 beat_vmask=0b00000010 -> wr_en=0xF0; repeat with vmask=0 -> wr_en=0x00, done=1.
- vd=0 LMUL1 vl=8 -> beat accepted, wr_en=0x00, done=1. vd=3 LMUL2 -> err=1 one cycle, beat_ready never 1, cmd_ready=1 next cycle. vl=0 -> done=1 one cycle after accept, beat_ready never 1.
- LMUL4 vd=4 SEW8 vl=32 with beat_valid low 3 cycles between beats -> four writes to 4,5,6,7, each wr_en=0xFF; wr_en=0 during gaps; single done pulse.
- nreset asserted after 2nd of 4 beats -> all outputs 0 asynchronously, no done. After release cmd_ready=1; a new LMUL1 command to vd=6 completes normally.

Source files
------------

// File: rtl/vreg_writeback_seq.sv
// Writeback sequencer for the vector register file: takes one command, then one result
// beat per register of the group, and issues one registered byte-enabled write per beat.
module vreg_writeback_seq #(
  parameter int unsigned REG_LEN  = 64,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned LANES    = REG_LEN / 8,
  parameter int unsigned VL_W     = $clog2(LANES * 4) + 1
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_vd,
  input  logic [1:0]         cmd_lmul,
  input  logic [1:0]         cmd_sew,
  input  logic [VL_W-1:0]    cmd_vl,
  input  logic               cmd_vm,
  input  logic               beat_valid,
  output logic               beat_ready,
  input  logic [REG_LEN-1:0] beat_data,
  input  logic [LANES-1:0]   beat_vmask,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [LANES-1:0]   wr_en,
  output logic [REG_LEN-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned LANE_W = $clog2(LANES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [ADDR_W-1:0]  vd_q, vd_d;
  logic [1:0]         lmul_q, lmul_d;
  logic [1:0]         sew_q, sew_d;
  logic [VL_W-1:0]    vl_q, vl_d;
  logic               vm_q, vm_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [LANES-1:0]   wr_en_q, wr_en_d;
  logic [REG_LEN-1:0] wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [1:0]         cmd_lmul_eff, cmd_sew_eff;
  logic [ADDR_W-1:0]  align_mask;
  logic               cmd_fire, beat_fire;
  logic [1:0]         last_k;
  logic [VL_W-1:0]    epr, vl_cap, vl_eff, base, elem;
  logic [ADDR_W:0]    addr_sum;
  logic [ADDR_W-1:0]  beat_addr;
  logic [LANE_W-1:0]  lane;
  logic [LANES-1:0]   beat_en;

  assign cmd_ready  = nreset && (state_q == ST_IDLE);
  assign beat_ready = (state_q == ST_BEAT);
  assign busy       = (state_q == ST_BEAT);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign beat_fire  = beat_valid && beat_ready;

  // Write-enable generation for the beat currently on the input.
  always_comb begin
    cmd_lmul_eff = (cmd_lmul == 2'd3) ? 2'd2 : cmd_lmul;
    cmd_sew_eff  = (cmd_sew == 2'd3) ? 2'd2 : cmd_sew;
    align_mask   = ADDR_W'((32'd1 << cmd_lmul_eff) - 32'd1);
    last_k       = 2'((3'd1 << lmul_q) - 3'd1);
    epr          = VL_W'(LANES >> sew_q);
    vl_cap       = epr << lmul_q;
    vl_eff       = (vl_q < vl_cap) ? vl_q : vl_cap;
    base         = epr * VL_W'(k_q);
    addr_sum     = (ADDR_W + 1)'(vd_q) + (ADDR_W + 1)'(k_q);
    beat_addr    = (addr_sum >= (ADDR_W + 1)'(NUM_REGS)) ?
                   ADDR_W'(addr_sum - (ADDR_W + 1)'(NUM_REGS)) : ADDR_W'(addr_sum);
    lane         = '0;
    elem         = '0;
    beat_en      = '0;
    for (int unsigned b = 0; b < LANES; b++) begin
      lane       = LANE_W'(b) >> sew_q;
      elem       = base + VL_W'(lane);
      beat_en[b] = (elem < vl_eff) && (vm_q || beat_vmask[lane]);
    end
    // Register 0 is never written.
    if (beat_addr == '0) beat_en = '0;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    vd_d      = vd_q;
    lmul_d    = lmul_q;
    sew_d     = sew_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          vd_d   = cmd_vd;
          lmul_d = cmd_lmul_eff;
          sew_d  = cmd_sew_eff;
          vl_d   = cmd_vl;
          vm_d   = cmd_vm;
          k_d    = 2'd0;
          if ((cmd_vd & align_mask) != '0) begin
            err_d = 1'b1;
          end else if (cmd_vl == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_BEAT;
          end
        end
      end
      ST_BEAT: begin
        if (beat_fire) begin
          wr_addr_d = beat_addr;
          wr_data_d = beat_data;
          wr_en_d   = beat_en;
          if (k_q == last_k) begin
            state_d = ST_FLUSH;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      vd_q      <= '0;
      lmul_q    <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      vd_q      <= vd_d;
      lmul_q    <= lmul_d;
      sew_q     <= sew_d;
      vl_q      <= vl_d;
      vm_q      <= vm_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_vreg_writeback_seq.sv
// Scoreboard bench for vreg_writeback_seq: drivers queue expected writes and pulses,
// an independent monitor pops and compares them as the DUT presents them.
module tb_vreg_writeback_seq;

  localparam int unsigned REG_LEN  = 64;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned LANES    = 8;
  localparam int unsigned VL_W     = 6;

  logic               clk = 1'b0;
  logic               nreset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [ADDR_W-1:0]  cmd_vd = '0;
  logic [1:0]         cmd_lmul = '0;
  logic [1:0]         cmd_sew = '0;
  logic [VL_W-1:0]    cmd_vl = '0;
  logic               cmd_vm = 1'b0;
  logic               beat_valid = 1'b0;
  logic               beat_ready;
  logic [REG_LEN-1:0] beat_data = '0;
  logic [LANES-1:0]   beat_vmask = '0;
  logic [ADDR_W-1:0]  wr_addr;
  logic [LANES-1:0]   wr_en;
  logic [REG_LEN-1:0] wr_data;
  logic               busy, done, err;

  vreg_writeback_seq #(
    .REG_LEN (REG_LEN),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .LANES   (LANES),
    .VL_W    (VL_W)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_vd    (cmd_vd),
    .cmd_lmul  (cmd_lmul),
    .cmd_sew   (cmd_sew),
    .cmd_vl    (cmd_vl),
    .cmd_vm    (cmd_vm),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_data (beat_data),
    .beat_vmask(beat_vmask),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  en;
    logic [63:0] data;
  } wr_t;
  typedef struct {
    bit is_err;
    int at;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event, want none", name);
  endtask

  // Monitor: outputs at each negedge reflect the handshake seen at the previous negedge.
  initial begin
    bit  acc;
    wr_t w;
    ev_t ev;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        acc = 1'b0;
        continue;
      end
      if (acc) begin
        if (wq.size() == 0) fail_now("write");
        else begin
          w = wq.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(w.addr));
          chk("wr_en", 64'(wr_en), 64'(w.en));
          chk("wr_data", wr_data, w.data);
        end
      end else begin
        chk("wr_en without beat", 64'(wr_en), 64'd0);
      end
      if (done || err) begin
        if (eq.size() == 0) fail_now("done/err pulse");
        else begin
          ev = eq.pop_front();
          chk("done pulse", 64'(done), 64'(!ev.is_err));
          chk("err pulse", 64'(err), 64'(ev.is_err));
          chk("pulse cycle", 64'(cyc), 64'(ev.at));
        end
      end
      acc = beat_valid && beat_ready;
    end
  end

  // kind: 0 = beats follow, 1 = immediate done, 2 = immediate err
  task automatic do_cmd(input logic [2:0] vd, input logic [1:0] lmul, input logic [1:0] sew,
                        input logic [5:0] vl, input logic vm, input int kind);
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_vd    = vd;
    cmd_lmul  = lmul;
    cmd_sew   = sew;
    cmd_vl    = vl;
    cmd_vm    = vm;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin
      fail_now("cmd_ready timeout");
    end else if (kind == 1) begin
      eq.push_back(ev_t'{1'b0, cyc + 1});
    end else if (kind == 2) begin
      eq.push_back(ev_t'{1'b1, cyc + 1});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_beat(input logic [63:0] data, input logic [7:0] vmask,
                         input logic [2:0] exp_addr, input logic [7:0] exp_en,
                         input bit last, input int gap);
    int n;
    @(posedge clk);
    #1;
    beat_valid = 1'b1;
    beat_data  = data;
    beat_vmask = vmask;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!beat_ready && n < 50);
    if (!beat_ready) begin
      fail_now("beat_ready timeout");
    end else begin
      wq.push_back(wr_t'{exp_addr, exp_en, data});
      if (last) eq.push_back(ev_t'{1'b0, cyc + 1});
    end
    @(posedge clk);
    #1;
    beat_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic after_last(input string name);
    @(negedge clk);
    chk({name, " cmd_ready in flush"}, 64'(cmd_ready), 64'd0);
    chk({name, " busy in flush"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({name, " cmd_ready after done"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic no_beats(input string name);
    repeat (3) begin
      @(negedge clk);
      chk({name, " beat_ready"}, 64'(beat_ready), 64'd0);
      chk({name, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " wr_addr"}, 64'(wr_addr), 64'd0);
    chk({name, " wr_en"}, 64'(wr_en), 64'd0);
    chk({name, " wr_data"}, wr_data, 64'd0);
    chk({name, " busy"}, 64'(busy), 64'd0);
    chk({name, " done"}, 64'(done), 64'd0);
    chk({name, " err"}, 64'(err), 64'd0);
    chk({name, " beat_ready"}, 64'(beat_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 nreset = 1'b0;
    #2;
    chk_zero("reset");
    #19 nreset = 1'b1;
    #1;
    chk("cmd_ready after reset", 64'(cmd_ready), 64'd1);

    // SEW8 LMUL1 vd=3 vl=5
    do_cmd(3'd3, 2'd0, 2'd0, 6'd5, 1'b1, 0);
    do_beat(64'h1122334455667788, 8'h00, 3'd3, 8'h1F, 1'b1, 0);
    after_last("sew8");

    // SEW16 LMUL2 vd=4 vl=6
    do_cmd(3'd4, 2'd1, 2'd1, 6'd6, 1'b1, 0);
    do_beat(64'hA0A1A2A3A4A5A6A7, 8'h00, 3'd4, 8'hFF, 1'b0, 0);
    do_beat(64'hB0B1B2B3B4B5B6B7, 8'h00, 3'd5, 8'h0F, 1'b1, 0);
    after_last("sew16");

    // SEW32 masked, element 1 active then none
    do_cmd(3'd2, 2'd0, 2'd2, 6'd2, 1'b0, 0);
    do_beat(64'hCAFEF00DDEADBEEF, 8'b0000_0010, 3'd2, 8'hF0, 1'b1, 0);
    do_cmd(3'd2, 2'd0, 2'd2, 6'd2, 1'b0, 0);
    do_beat(64'h0123456789ABCDEF, 8'b0000_0000, 3'd2, 8'h00, 1'b1, 0);

    // register 0 never written
    do_cmd(3'd0, 2'd0, 2'd0, 6'd8, 1'b1, 0);
    do_beat(64'hFFFFFFFFFFFFFFFF, 8'h00, 3'd0, 8'h00, 1'b1, 0);

    // misaligned group and empty vl
    do_cmd(3'd3, 2'd1, 2'd0, 6'd8, 1'b1, 2);
    no_beats("misaligned");
    do_cmd(3'd1, 2'd0, 2'd0, 6'd0, 1'b1, 1);
    no_beats("vl0");

    // SEW=3 behaves as SEW32; tail register of an LMUL2 group gets no enables
    do_cmd(3'd5, 2'd0, 2'd3, 6'd1, 1'b1, 0);
    do_beat(64'h5555666677778888, 8'h00, 3'd5, 8'h0F, 1'b1, 0);
    do_cmd(3'd6, 2'd1, 2'd0, 6'd3, 1'b1, 0);
    do_beat(64'h1111111111111111, 8'h00, 3'd6, 8'h07, 1'b0, 0);
    do_beat(64'h2222222222222222, 8'h00, 3'd7, 8'h00, 1'b1, 0);

    // LMUL4 with 3-cycle gaps between beats
    do_cmd(3'd4, 2'd2, 2'd0, 6'd32, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      do_beat(64'hD000000000000000 + 64'(i), 8'h00, 3'(4 + i), 8'hFF, (i == 3), 3);
    end
    repeat (2) @(posedge clk);

    // reset after the 2nd of 4 beats aborts the command
    do_cmd(3'd4, 2'd2, 2'd0, 6'd32, 1'b1, 0);
    do_beat(64'hE0E0E0E0E0E0E0E0, 8'h00, 3'd4, 8'hFF, 1'b0, 0);
    do_beat(64'hE1E1E1E1E1E1E1E1, 8'h00, 3'd5, 8'hFF, 1'b0, 0);
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    chk_zero("mid reset");
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    #1;
    chk("cmd_ready after mid reset", 64'(cmd_ready), 64'd1);
    do_cmd(3'd6, 2'd0, 2'd0, 6'd8, 1'b1, 0);
    do_beat(64'h6666666666666666, 8'h00, 3'd6, 8'hFF, 1'b1, 0);
    after_last("post reset");

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("writes outstanding", 64'(wq.size()), 64'd0);
    chk("pulses outstanding", 64'(eq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
